// File: rtl/udp_rx_if.sv
// Byte-stream input and parsed-header / payload output bundle of the UDP receiver.
interface udp_rx_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        i_rx_sof;
    logic        i_rx_eof;
    logic        o_hdr_valid;
    logic [15:0] o_src_port;
    logic [15:0] o_dst_port;
    logic [10:0] o_data_length;
    logic [15:0] o_checksum;
    logic        o_pl_valid;
    logic [7:0]  o_pl_data;
    logic        o_pl_last;
    logic        o_drop;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;

    modport slave (
        input  i_rx_valid, i_rx_data, i_rx_sof, i_rx_eof,
        output o_hdr_valid, o_src_port, o_dst_port, o_data_length, o_checksum,
        output o_pl_valid, o_pl_data, o_pl_last, o_drop, o_err, o_err_code, o_busy
    );

    modport master (
        output i_rx_valid, i_rx_data, i_rx_sof, i_rx_eof,
        input  o_hdr_valid, o_src_port, o_dst_port, o_data_length, o_checksum,
        input  o_pl_valid, o_pl_data, o_pl_last, o_drop, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/udp_rx.sv
// UDP receive parser: strips the 8-byte header, filters on destination port,
// forwards payload bytes, discards Ethernet padding and flags malformed frames.
module udp_rx #(
    parameter logic [15:0] P_LOCAL_PORT  = 16'd8080,
    parameter bit          P_PORT_FILTER = 1'b1,
    parameter logic [10:0] P_MAX_PAYLOAD = 11'd1472
) (
    input  logic     i_clk,
    input  logic     i_rst,
    udp_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    function automatic logic len_bad(input logic [15:0] len);
        return (len < 16'd8) || ((len - 16'd8) > {5'd0, P_MAX_PAYLOAD});
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  hdr_cnt_r, hdr_cnt_s;
    logic [15:0] src_sh_r, src_sh_s, dst_sh_r, dst_sh_s;
    logic [15:0] len_sh_r, len_sh_s, csum_sh_r, csum_sh_s;
    logic [15:0] pl_len_s;
    logic [10:0] rem_r, rem_s;
    logic        hdr_valid_s, pl_valid_s, pl_last_s, drop_s, err_s;
    logic [1:0]  err_code_s;

    logic        hdr_valid_r, pl_valid_r, pl_last_r, drop_r, err_r, busy_r;
    logic [1:0]  err_code_r;
    logic [7:0]  pl_data_r;
    logic [15:0] src_r, dst_r, csum_r;
    logic [10:0] dlen_r;

    // Next-state, shadow-header and output-pulse decode for one accepted byte.
    always_comb begin
        state_s     = state_r;
        hdr_cnt_s   = hdr_cnt_r;
        src_sh_s    = src_sh_r;
        dst_sh_s    = dst_sh_r;
        len_sh_s    = len_sh_r;
        csum_sh_s   = csum_sh_r;
        rem_s       = rem_r;
        hdr_valid_s = 1'b0;
        pl_valid_s  = 1'b0;
        pl_last_s   = 1'b0;
        drop_s      = 1'b0;
        err_s       = 1'b0;
        err_code_s  = 2'd0;
        pl_len_s    = len_sh_r - 16'd8;
        if (bus.i_rx_valid) begin
            if (bus.i_rx_sof) begin
                // Any sof restarts header capture; an interrupted frame is an abort.
                src_sh_s  = {bus.i_rx_data, 8'h00};
                hdr_cnt_s = 3'd1;
                state_s   = ST_HDR;
                if (state_r == ST_HDR || state_r == ST_PAYLOAD) begin
                    err_s      = 1'b1;
                    err_code_s = 2'd3;
                    if (bus.i_rx_eof) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HDR;
                    end
                end else if (bus.i_rx_eof) begin
                    err_s      = 1'b1;
                    err_code_s = 2'd1;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_HDR;
                end
            end else begin
                case (state_r)
                    ST_HDR: begin
                        hdr_cnt_s = hdr_cnt_r + 3'd1;
                        case (hdr_cnt_r)
                            3'd1:    src_sh_s[7:0]   = bus.i_rx_data;
                            3'd2:    dst_sh_s[15:8]  = bus.i_rx_data;
                            3'd3:    dst_sh_s[7:0]   = bus.i_rx_data;
                            3'd4:    len_sh_s[15:8]  = bus.i_rx_data;
                            3'd5:    len_sh_s[7:0]   = bus.i_rx_data;
                            3'd6:    csum_sh_s[15:8] = bus.i_rx_data;
                            3'd7:    csum_sh_s[7:0]  = bus.i_rx_data;
                            default: hdr_cnt_s       = 3'd0;
                        endcase
                        if (hdr_cnt_r == 3'd7) begin
                            hdr_cnt_s = 3'd0;
                            if (len_bad(len_sh_r)) begin
                                err_s      = 1'b1;
                                err_code_s = 2'd2;
                                state_s    = bus.i_rx_eof ? ST_IDLE : ST_DROP;
                            end else if (P_PORT_FILTER && (dst_sh_r != P_LOCAL_PORT)) begin
                                drop_s  = 1'b1;
                                state_s = bus.i_rx_eof ? ST_IDLE : ST_DROP;
                            end else if (pl_len_s == 16'd0) begin
                                hdr_valid_s = 1'b1;
                                state_s     = bus.i_rx_eof ? ST_IDLE : ST_DROP;
                            end else if (bus.i_rx_eof) begin
                                // Header promises payload but the frame ends here.
                                err_s      = 1'b1;
                                err_code_s = 2'd1;
                                state_s    = ST_IDLE;
                            end else begin
                                hdr_valid_s = 1'b1;
                                rem_s       = pl_len_s[10:0];
                                state_s     = ST_PAYLOAD;
                            end
                        end else if (bus.i_rx_eof) begin
                            err_s      = 1'b1;
                            err_code_s = 2'd1;
                            state_s    = ST_IDLE;
                        end else begin
                            state_s = ST_HDR;
                        end
                    end
                    ST_PAYLOAD: begin
                        pl_valid_s = 1'b1;
                        rem_s      = rem_r - 11'd1;
                        if (rem_r == 11'd1) begin
                            pl_last_s = 1'b1;
                            state_s   = bus.i_rx_eof ? ST_IDLE : ST_DROP;
                        end else if (bus.i_rx_eof) begin
                            pl_last_s  = 1'b1;
                            err_s      = 1'b1;
                            err_code_s = 2'd1;
                            state_s    = ST_IDLE;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end
                    ST_DROP: begin
                        if (bus.i_rx_eof) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_DROP;
                        end
                    end
                    default: state_s = ST_IDLE;
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, shadow header and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            hdr_cnt_r   <= 3'd0;
            src_sh_r    <= 16'd0;
            dst_sh_r    <= 16'd0;
            len_sh_r    <= 16'd0;
            csum_sh_r   <= 16'd0;
            rem_r       <= 11'd0;
            hdr_valid_r <= 1'b0;
            pl_valid_r  <= 1'b0;
            pl_last_r   <= 1'b0;
            pl_data_r   <= 8'd0;
            drop_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
            busy_r      <= 1'b0;
            src_r       <= 16'd0;
            dst_r       <= 16'd0;
            dlen_r      <= 11'd0;
            csum_r      <= 16'd0;
        end else begin
            state_r     <= state_s;
            hdr_cnt_r   <= hdr_cnt_s;
            src_sh_r    <= src_sh_s;
            dst_sh_r    <= dst_sh_s;
            len_sh_r    <= len_sh_s;
            csum_sh_r   <= csum_sh_s;
            rem_r       <= rem_s;
            hdr_valid_r <= hdr_valid_s;
            pl_valid_r  <= pl_valid_s;
            pl_last_r   <= pl_last_s;
            drop_r      <= drop_s;
            err_r       <= err_s;
            err_code_r  <= err_code_s;
            busy_r      <= (state_s != ST_IDLE);
            if (pl_valid_s) begin
                pl_data_r <= bus.i_rx_data;
            end
            if (hdr_valid_s) begin
                src_r  <= src_sh_s;
                dst_r  <= dst_sh_s;
                dlen_r <= pl_len_s[10:0];
                csum_r <= csum_sh_s;
            end
        end
    end

    assign bus.o_hdr_valid   = hdr_valid_r;
    assign bus.o_src_port    = src_r;
    assign bus.o_dst_port    = dst_r;
    assign bus.o_data_length = dlen_r;
    assign bus.o_checksum    = csum_r;
    assign bus.o_pl_valid    = pl_valid_r;
    assign bus.o_pl_data     = pl_data_r;
    assign bus.o_pl_last     = pl_last_r;
    assign bus.o_drop        = drop_r;
    assign bus.o_err         = err_r;
    assign bus.o_err_code    = err_code_r;
    assign bus.o_busy        = busy_r;

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: filtered and unfiltered instances share one input stream.
module tb_udp_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    udp_rx_if bus ();
    udp_rx_if bus2 ();

    assign bus2.i_rx_valid = bus.i_rx_valid;
    assign bus2.i_rx_data  = bus.i_rx_data;
    assign bus2.i_rx_sof   = bus.i_rx_sof;
    assign bus2.i_rx_eof   = bus.i_rx_eof;

    udp_rx dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    udp_rx #(.P_PORT_FILTER(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, n_hdr = 0, n_err = 0, n_drop = 0, n_last = 0, last_idx = 0;
    int err_with_last = 0, hdr_cyc = 0, first_pl_cyc = 0, n_hdr2 = 0, n_pl2 = 0;
    logic [1:0] err_code = 2'd0;
    logic [7:0] pl_q[$];
    logic [7:0] fq[$];

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.o_hdr_valid) begin
            n_hdr   = n_hdr + 1;
            hdr_cyc = cyc;
        end
        if (bus.o_pl_valid) begin
            if (pl_q.size() == 0) first_pl_cyc = cyc;
            pl_q.push_back(bus.o_pl_data);
            if (bus.o_pl_last) begin
                n_last   = n_last + 1;
                last_idx = pl_q.size();
                if (bus.o_err) err_with_last = err_with_last + 1;
            end
        end
        if (bus.o_err) begin
            n_err    = n_err + 1;
            err_code = bus.o_err_code;
        end
        if (bus.o_drop) n_drop = n_drop + 1;
        if (bus2.o_hdr_valid) n_hdr2 = n_hdr2 + 1;
        if (bus2.o_pl_valid) n_pl2 = n_pl2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_hdr = 0; n_err = 0; n_drop = 0; n_last = 0; last_idx = 0;
        err_with_last = 0; n_hdr2 = 0; n_pl2 = 0; err_code = 2'd0;
        pl_q.delete();
    endtask

    task automatic put_hdr(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] c);
        fq.push_back(s[15:8]); fq.push_back(s[7:0]);
        fq.push_back(d[15:8]); fq.push_back(d[7:0]);
        fq.push_back(l[15:8]); fq.push_back(l[7:0]);
        fq.push_back(c[15:8]); fq.push_back(c[7:0]);
    endtask

    task automatic send(input bit eof_last);
        for (int i = 0; i < fq.size(); i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = fq[i];
            bus.i_rx_sof   = (i == 0);
            bus.i_rx_eof   = eof_last && (i == fq.size() - 1);
            @(posedge clk); #1;
        end
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sof   = 1'b0;
        bus.i_rx_eof   = 1'b0;
        fq.delete();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_sof   = 1'b0;
        bus.i_rx_eof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_src", {16'd0, bus.o_src_port}, 32'd0);
        check("rst_hdr_valid", {31'd0, bus.o_hdr_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_mon();

        // 1: basic accepted frame
        put_hdr(16'd1234, 16'd8080, 16'h000C, 16'hABCD);
        fq.push_back(8'hDE); fq.push_back(8'hAD); fq.push_back(8'hBE); fq.push_back(8'hEF);
        send(1'b1);
        settle();
        check("t1_hdr_cnt", n_hdr, 32'd1);
        check("t1_src", {16'd0, bus.o_src_port}, 32'd1234);
        check("t1_dst", {16'd0, bus.o_dst_port}, 32'd8080);
        check("t1_len", {21'd0, bus.o_data_length}, 32'd4);
        check("t1_csum", {16'd0, bus.o_checksum}, 32'h0000ABCD);
        check("t1_pl_cnt", pl_q.size(), 32'd4);
        check("t1_pl_data", (pl_q.size() == 4) ? {pl_q[0], pl_q[1], pl_q[2], pl_q[3]} : 32'd0, 32'hDEADBEEF);
        check("t1_last", {n_last[15:0], last_idx[15:0]}, {16'd1, 16'd4});
        check("t1_err", n_err, 32'd0);
        check("t1_hdr_to_pl", first_pl_cyc - hdr_cyc, 32'd1);
        check("t1_busy_idle", {31'd0, bus.o_busy}, 32'd0);
        clear_mon();

        // 2: same frame with 14 pad bytes
        put_hdr(16'd1234, 16'd8080, 16'h000C, 16'hABCD);
        fq.push_back(8'hDE); fq.push_back(8'hAD); fq.push_back(8'hBE); fq.push_back(8'hEF);
        for (int i = 0; i < 14; i++) fq.push_back(8'h00);
        send(1'b1);
        settle();
        check("t2_hdr_cnt", n_hdr, 32'd1);
        check("t2_pl_cnt", pl_q.size(), 32'd4);
        check("t2_last", {n_last[15:0], last_idx[15:0]}, {16'd1, 16'd4});
        check("t2_err", n_err, 32'd0);
        check("t2_busy_idle", {31'd0, bus.o_busy}, 32'd0);
        clear_mon();

        // 3: destination port mismatch
        put_hdr(16'd1234, 16'd9999, 16'h000C, 16'h1111);
        fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
        send(1'b1);
        settle();
        check("t3_drop", n_drop, 32'd1);
        check("t3_no_hdr", n_hdr, 32'd0);
        check("t3_no_pl", pl_q.size(), 32'd0);
        check("t3_dst_held", {16'd0, bus.o_dst_port}, 32'd8080);
        check("t3_nofilt_hdr", n_hdr2, 32'd1);
        check("t3_nofilt_pl", n_pl2, 32'd4);
        check("t3_nofilt_dst", {16'd0, bus2.o_dst_port}, 32'd9999);
        clear_mon();

        // 4a: length below header size
        put_hdr(16'd1234, 16'd8080, 16'h0006, 16'h0000);
        send(1'b1);
        settle();
        check("t4a_err", {n_err[15:0], 14'd0, err_code}, {16'd1, 16'd2});
        check("t4a_no_hdr", n_hdr, 32'd0);
        clear_mon();

        // 4b: payload length 1481 exceeds maximum
        put_hdr(16'd1234, 16'd8080, 16'h05D1, 16'h0000);
        fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
        send(1'b1);
        settle();
        check("t4b_err", {n_err[15:0], 14'd0, err_code}, {16'd1, 16'd2});
        check("t4b_no_pl", pl_q.size(), 32'd0);
        check("t4b_no_hdr", n_hdr, 32'd0);
        clear_mon();

        // 5: frame ends after 3 of 8 payload bytes
        put_hdr(16'd4321, 16'd8080, 16'h0010, 16'h0000);
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        send(1'b1);
        settle();
        check("t5_pl_cnt", pl_q.size(), 32'd3);
        check("t5_last", {n_last[15:0], last_idx[15:0]}, {16'd1, 16'd3});
        check("t5_err", {n_err[15:0], 14'd0, err_code}, {16'd1, 16'd1});
        check("t5_err_with_last", err_with_last, 32'd1);
        clear_mon();

        // 6a: sof on the second payload byte aborts, then a full frame follows
        put_hdr(16'd1234, 16'd8080, 16'h000C, 16'h0000);
        fq.push_back(8'h11);
        send(1'b0);
        put_hdr(16'h1111, 16'd8080, 16'h000C, 16'h2222);
        fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
        send(1'b1);
        settle();
        check("t6_err", {n_err[15:0], 14'd0, err_code}, {16'd1, 16'd3});
        check("t6_hdr_cnt", n_hdr, 32'd2);
        check("t6_src", {16'd0, bus.o_src_port}, 32'h00001111);
        check("t6_pl_cnt", pl_q.size(), 32'd5);
        check("t6_pl_tail", (pl_q.size() == 5) ? {pl_q[1], pl_q[2], pl_q[3], pl_q[4]} : 32'd0, 32'h01020304);
        check("t6_last", {n_last[15:0], last_idx[15:0]}, {16'd1, 16'd5});
        clear_mon();

        // 6b: reset in the middle of a payload
        put_hdr(16'd1234, 16'd8080, 16'h000C, 16'h0000);
        fq.push_back(8'h55); fq.push_back(8'h66);
        send(1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        settle();
        check("t6r_err", n_err, 32'd0);
        check("t6r_last", n_last, 32'd0);
        check("t6r_busy", {31'd0, bus.o_busy}, 32'd0);
        check("t6r_src", {16'd0, bus.o_src_port}, 32'd0);
        check("t6r_len", {21'd0, bus.o_data_length}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
